// File: rtl/counter_phase_sequencer.sv
// Steps one external modulo Counter through a table of timed phases.
// Each phase loads a terminal count, counts on tick, and ends when the Counter raises its flag.
module counter_phase_sequencer #(
   parameter int NBitsForCounter = 5,
   parameter int NUM_PHASES      = 4,
   parameter int PHASE_W         = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       abort,
   input  logic                       loop_mode,
   input  logic                       tick,
   input  logic                       cfg_we,
   input  logic [PHASE_W-1:0]         cfg_addr,
   input  logic [NBitsForCounter-1:0] cfg_data,
   input  logic                       cnt_flag,
   output logic                       cnt_enb,
   output logic                       cnt_sync_rst,
   output logic [NBitsForCounter-1:0] cnt_max,
   output logic                       busy,
   output logic [PHASE_W-1:0]         phase,
   output logic                       phase_end,
   output logic                       done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_ABORT = 3'd4;

   localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

   logic [2:0]                 state_q, state_d;
   logic [PHASE_W-1:0]         phase_q, phase_d;
   logic [NBitsForCounter-1:0] table_q [NUM_PHASES];
   logic [NUM_PHASES-1:0]      tbl_we;
   logic                       phase_done;

   // The table is only writable while idle so a running sequence never sees a value change.
   generate
      for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_tbl_we
         assign tbl_we[gi] = cfg_we && (state_q == S_IDLE) && (32'(cfg_addr) == gi);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_PHASES; i++) begin
            table_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_PHASES; i++) begin
            if (tbl_we[i]) begin
               table_q[i] <= cfg_data;
            end
         end
      end
   end

   // Abort wins over a coincident phase end, so no phase_end is reported then.
   assign phase_done = (state_q == S_RUN) && tick && cnt_flag && !abort;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CLEAR;
               phase_d = '0;
            end
         end
         S_CLEAR: begin
            state_d = abort ? S_ABORT : S_RUN;
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_ABORT;
            end else if (phase_done) begin
               if (phase_q != LAST_PHASE) begin
                  phase_d = phase_q + 1'b1;
               end else if (loop_mode) begin
                  phase_d = '0;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            phase_d = '0;
         end
         S_ABORT: begin
            state_d = S_IDLE;
            phase_d = '0;
         end
         default: begin
            state_d = S_IDLE;
            phase_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         phase_q <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
      end
   end

   always_comb begin
      cnt_enb      = 1'b0;
      cnt_sync_rst = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (state_q)
         S_CLEAR: begin
            cnt_enb      = 1'b1;
            cnt_sync_rst = 1'b1;
            busy         = 1'b1;
         end
         S_RUN: begin
            cnt_enb = tick;
            busy    = 1'b1;
         end
         S_DONE: begin
            done = 1'b1;
         end
         S_ABORT: begin
            cnt_enb      = 1'b1;
            cnt_sync_rst = 1'b1;
            busy         = 1'b1;
         end
         default: begin
            cnt_enb = 1'b0;
         end
      endcase
   end

   assign cnt_max   = table_q[phase_q];
   assign phase     = phase_q;
   assign phase_end = phase_done;

endmodule

// File: tb/tb_counter_phase_sequencer.sv
// Directed bench for counter_phase_sequencer with a behavioural modulo Counter attached.
module tb_counter_phase_sequencer;
   localparam int NB = 5;
   localparam int NP = 4;
   localparam int PW = 2;

   logic          clk = 1'b0;
   logic          rst, start, abort, loop_mode, tick, cfg_we, cnt_flag;
   logic [PW-1:0] cfg_addr;
   logic [NB-1:0] cfg_data;
   logic          cnt_enb, cnt_sync_rst, busy, phase_end, done;
   logic [NB-1:0] cnt_max;
   logic [PW-1:0] phase;
   logic [NB-1:0] cnt_q;

   int tests_run = 0;
   int fails     = 0;
   bit tick_alt  = 1'b0;

   counter_phase_sequencer #(.NBitsForCounter(NB), .NUM_PHASES(NP), .PHASE_W(PW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .loop_mode(loop_mode),
      .tick(tick), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cnt_flag(cnt_flag), .cnt_enb(cnt_enb), .cnt_sync_rst(cnt_sync_rst),
      .cnt_max(cnt_max), .busy(busy), .phase(phase), .phase_end(phase_end), .done(done)
   );

   always #5 clk = ~clk;

   // Modulo counter: wraps to 0 after reaching N_input, flag while count equals N_input.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else if (cnt_enb) cnt_q <= (cnt_sync_rst || cnt_q == cnt_max) ? '0 : cnt_q + 1'b1;
   end
   assign cnt_flag = (cnt_q == cnt_max);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cfg(input int addr, input int data);
      cfg_we   = 1'b1;
      cfg_addr = PW'(addr);
      cfg_data = NB'(data);
      step();
      cfg_we = 1'b0;
   endtask

   // Leaves the bench at the negedge of RUN cycle 1.
   task automatic begin_seq();
      start = 1'b1;
      #1;
      chk("idle_busy", busy, 0);
      step();
      start = 1'b0;
      #1;
      chk("clear_enb", cnt_enb, 1);
      chk("clear_srst", cnt_sync_rst, 1);
      chk("clear_busy", busy, 1);
      step();
   endtask

   task automatic run_cycles(input logic [31:0] mask, input int first, input int last);
      for (int c = first; c <= last; c++) begin
         tick = tick_alt ? (c % 2 == 0) : 1'b1;
         #1;
         chk($sformatf("phase_end_c%0d", c), phase_end, mask[c]);
         chk($sformatf("run_done_c%0d", c), done, 0);
         step();
      end
   endtask

   task automatic finish_done();
      #1;
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 0);
      chk("done_enb", cnt_enb, 0);
      step();
      #1;
      chk("after_done", done, 0);
      chk("after_done_phase", phase, 0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; abort = 1'b0; loop_mode = 1'b0; tick = 1'b1;
      cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_enb", cnt_enb, 0);
      chk("rst_srst", cnt_sync_rst, 0);
      chk("rst_max", cnt_max, 0);
      chk("rst_phase", phase, 0);
      chk("rst_done", done, 0);
      @(negedge clk);
      rst = 1'b1;

      // table {2,0,3,1}, tick always high: ends at RUN cycles 3,4,8,10
      cfg(0, 2); cfg(1, 0); cfg(2, 3); cfg(3, 1);
      begin_seq();
      #1 chk("run_max0", cnt_max, 2);
      run_cycles(32'h0000_0518, 1, 10);
      finish_done();

      // tick every 2nd cycle: ends at 6,8,16,20
      tick_alt = 1'b1;
      begin_seq();
      run_cycles(32'h0011_0140, 1, 20);
      finish_done();
      tick_alt = 1'b0;

      // loop mode, table {1,1,1,1}: ends every 2 cycles, wraps 3->0
      cfg(0, 1); cfg(1, 1); cfg(2, 1); cfg(3, 1);
      loop_mode = 1'b1;
      begin_seq();
      run_cycles(32'h0000_1554, 1, 7);
      #1 chk("loop_phase3", phase, 3);
      run_cycles(32'h0000_1554, 8, 8);
      #1 chk("loop_wrap", phase, 0);
      run_cycles(32'h0000_1554, 9, 12);
      abort = 1'b1;
      #1 chk("loop_abort_pe", phase_end, 0);
      step();
      abort = 1'b0;
      #1;
      chk("abort_srst", cnt_sync_rst, 1);
      chk("abort_enb", cnt_enb, 1);
      chk("abort_done", done, 0);
      step();
      #1 chk("abort_idle", busy, 0);
      loop_mode = 1'b0;

      // abort in phase 2 with count 1
      cfg(0, 2); cfg(1, 0); cfg(2, 3); cfg(3, 1);
      begin_seq();
      run_cycles(32'h0000_0518, 1, 5);
      abort = 1'b1;
      #1;
      chk("ab_phase", phase, 2);
      chk("ab_count", cnt_q, 1);
      chk("ab_pe", phase_end, 0);
      step();
      abort = 1'b0;
      #1 chk("ab_state_busy", busy, 1);
      step();
      #1;
      chk("ab_idle_busy", busy, 0);
      chk("ab_idle_done", done, 0);
      chk("ab_cnt_zero", cnt_q, 0);

      // abort coincident with phase 0 end
      begin_seq();
      run_cycles(32'h0000_0518, 1, 2);
      tick = 1'b1; abort = 1'b1;
      #1;
      chk("co_flag", cnt_flag, 1);
      chk("co_pe", phase_end, 0);
      step();
      abort = 1'b0;
      #1;
      chk("co_abort_done", done, 0);
      chk("co_abort_srst", cnt_sync_rst, 1);
      step();
      #1;
      chk("co_idle_busy", busy, 0);
      chk("co_cnt_zero", cnt_q, 0);
      chk("co_phase", phase, 0);

      // table write while busy is ignored
      begin_seq();
      cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 5'd7;
      run_cycles(32'h0000_0518, 1, 1);
      cfg_we = 1'b0;
      run_cycles(32'h0000_0518, 2, 10);
      finish_done();

      // same write in IDLE: phase 1 lasts 8 ticks, ends at 3,11,15,17
      cfg(1, 7);
      begin_seq();
      run_cycles(32'h0002_8808, 1, 17);
      finish_done();

      // async reset mid-RUN clears everything including the table
      begin_seq();
      run_cycles(32'h0002_8808, 1, 5);
      rst = 1'b0;
      #1;
      chk("mrst_busy", busy, 0);
      chk("mrst_enb", cnt_enb, 0);
      chk("mrst_phase", phase, 0);
      chk("mrst_max", cnt_max, 0);
      chk("mrst_pe", phase_end, 0);
      chk("mrst_done", done, 0);
      @(negedge clk);
      rst = 1'b1;
      begin_seq();
      #1 chk("post_rst_max", cnt_max, 0);
      run_cycles(32'h0000_001E, 1, 4);
      finish_done();

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end
endmodule
